// File: rtl/ccip_line_reader.sv
// CCI-P c0 read engine: issues a run of single-line reads under a credit limit,
// streams the responses out in arrival order and keeps a 64-bit running checksum.
module ccip_line_reader #(
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [41:0]  base_addr,
   input  logic [15:0]  num_lines,
   output logic         busy,
   output logic         done,
   output logic [63:0]  checksum,
   output logic         c0_req_valid,
   output logic [41:0]  c0_req_addr,
   output logic [15:0]  c0_req_mdata,
   input  logic         c0_tx_almfull,
   input  logic         c0_rsp_valid,
   input  logic [15:0]  c0_rsp_mdata,
   input  logic [511:0] c0_rsp_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [15:0]  out_index,
   output logic [511:0] out_data
);
   // state   | meaning
   // S_IDLE  | waiting for start
   // S_ISSUE | issuing read requests while credits allow
   // S_DRAIN | all requests issued, waiting for the last delivery
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   localparam int AW = $clog2(MAX_OUTSTANDING);
   localparam int CW = AW + 1;
   localparam int EW = 16 + 512;

   state_t        state_q, state_d;
   logic [41:0]   base_q, base_d;
   logic [15:0]   num_q, num_d;
   logic [15:0]   req_cnt_q, req_cnt_d;
   logic [15:0]   dlv_cnt_q, dlv_cnt_d;
   logic [CW-1:0] credits_q, credits_d;
   logic [63:0]   checksum_q, checksum_d;
   logic          done_q, done_d;
   logic          req_valid_q, req_valid_d;
   logic [41:0]   req_addr_q, req_addr_d;
   logic [15:0]   req_mdata_q, req_mdata_d;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [EW-1:0] mem_q [MAX_OUTSTANDING];
   logic [EW-1:0] head;

   logic          issue;
   logic          out_hs;
   logic          fifo_full;

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (count_q != '0);
   assign out_index = head[EW-1:512];
   assign out_data  = head[511:0];
   assign out_hs    = out_valid && out_ready;
   assign fifo_full = (count_q == CW'(MAX_OUTSTANDING));

   assign issue = (state_q == S_ISSUE) && !c0_tx_almfull &&
                  (credits_q != '0) && (req_cnt_q < num_q);

   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign checksum     = checksum_q;
   assign c0_req_valid = req_valid_q;
   assign c0_req_addr  = req_addr_q;
   assign c0_req_mdata = req_mdata_q;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      num_d       = num_q;
      req_cnt_d   = req_cnt_q;
      done_d      = 1'b0;
      req_valid_d = issue;
      req_addr_d  = req_addr_q;
      req_mdata_d = req_mdata_q;
      credits_d   = credits_q - CW'(issue) + CW'(out_hs);
      dlv_cnt_d   = dlv_cnt_q + 16'(out_hs);
      checksum_d  = out_hs ? (checksum_q + out_data[63:0]) : checksum_q;

      if (issue) begin
         req_addr_d  = base_q + {26'd0, req_cnt_q};
         req_mdata_d = req_cnt_q;
         req_cnt_d   = req_cnt_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d     = base_addr;
               num_d      = num_lines;
               req_cnt_d  = 16'd0;
               dlv_cnt_d  = 16'd0;
               checksum_d = 64'd0;
               state_d    = (num_lines == 16'd0) ? S_DRAIN : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (req_cnt_d == num_q) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // completion is taken from the post-handshake count so done lines up with the last beat
            if (dlv_cnt_d == num_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = c0_rsp_valid ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = out_hs ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      count_d  = count_q + CW'(c0_rsp_valid) - CW'(out_hs);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         num_q       <= '0;
         req_cnt_q   <= '0;
         dlv_cnt_q   <= '0;
         credits_q   <= CW'(MAX_OUTSTANDING);
         checksum_q  <= '0;
         done_q      <= 1'b0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_mdata_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         num_q       <= num_d;
         req_cnt_q   <= req_cnt_d;
         dlv_cnt_q   <= dlv_cnt_d;
         credits_q   <= credits_d;
         checksum_q  <= checksum_d;
         done_q      <= done_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_mdata_q <= req_mdata_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // storage needs no reset; occupancy is tracked by count_q
   always_ff @(posedge clk) begin
      if (c0_rsp_valid) mem_q[wr_ptr_q] <= {c0_rsp_mdata, c0_rsp_data};
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
      !(c0_rsp_valid && fifo_full && !out_ready))
      else $error("ccip_line_reader: response written to full FIFO");

endmodule

// File: tb/tb_ccip_line_reader.sv
// Directed bench for ccip_line_reader: host responder queue, request/output monitors,
// hand-computed expectations for each scenario.
module tb_ccip_line_reader;
   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [41:0]  base_addr;
   logic [15:0]  num_lines;
   logic         busy;
   logic         done;
   logic [63:0]  checksum;
   logic         c0_req_valid;
   logic [41:0]  c0_req_addr;
   logic [15:0]  c0_req_mdata;
   logic         c0_tx_almfull;
   logic         c0_rsp_valid;
   logic [15:0]  c0_rsp_mdata;
   logic [511:0] c0_rsp_data;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_index;
   logic [511:0] out_data;

   ccip_line_reader #(.MAX_OUTSTANDING(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .num_lines(num_lines), .busy(busy), .done(done), .checksum(checksum),
      .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
      .c0_tx_almfull(c0_tx_almfull), .c0_rsp_valid(c0_rsp_valid),
      .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_data(out_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic        auto_rsp;
   logic [41:0] req_addr_log[$];
   logic [15:0] out_idx_log[$];
   logic [79:0] pend[$];

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // one clock: monitor at negedge, then drive responses just after the rising edge
   task automatic step();
      logic [79:0] e;
      @(negedge clk);
      if (c0_req_valid) begin
         req_addr_log.push_back(c0_req_addr);
         if (auto_rsp) pend.push_back({c0_req_mdata, 64'(c0_req_mdata) + 64'd1});
      end
      if (out_valid && out_ready) out_idx_log.push_back(out_index);
      @(posedge clk);
      #1;
      if (pend.size() != 0) begin
         e = pend.pop_front();
         c0_rsp_valid = 1'b1;
         c0_rsp_mdata = e[79:64];
         c0_rsp_data  = {e[79:64], 432'd0, e[63:0]};
      end else begin
         c0_rsp_valid = 1'b0;
      end
   endtask

   task automatic start_run(input logic [41:0] b, input logic [15:0] n);
      base_addr = b;
      num_lines = n;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input string tag);
      for (int i = 0; i < max_cyc && !done; i++) step();
      chk_val(tag, 64'(done), 64'd1);
   endtask

   function automatic int addr_errs(input int rb, input logic [41:0] b, input int n);
      int bad = 0;
      logic [41:0] e;
      for (int k = 0; k < n; k++) begin
         e = b + 42'(k);
         if (rb + k >= req_addr_log.size() || req_addr_log[rb + k] !== e) bad++;
      end
      return bad;
   endfunction

   int rb;
   int ob;
   int bad;

   initial begin
      reset_n = 1'b0; start = 1'b0; base_addr = '0; num_lines = '0;
      c0_tx_almfull = 1'b0; c0_rsp_valid = 1'b0; c0_rsp_mdata = '0; c0_rsp_data = '0;
      out_ready = 1'b0; auto_rsp = 1'b0;
      step(); step();
      chk_val("rst_busy", 64'(busy), 0);
      chk_val("rst_done", 64'(done), 0);
      chk_val("rst_checksum", checksum, 0);
      chk_val("rst_req_valid", 64'(c0_req_valid), 0);
      chk_val("rst_req_addr", 64'(c0_req_addr), 0);
      chk_val("rst_req_mdata", 64'(c0_req_mdata), 0);
      chk_val("rst_out_valid", 64'(out_valid), 0);
      reset_n = 1'b1;
      step();

      // single line
      rb = req_addr_log.size();
      start_run(42'h100, 16'd1);
      chk_val("t1_busy", 64'(busy), 1);
      chk_val("t1_req_early", 64'(c0_req_valid), 0);
      step();
      chk_val("t1_req_valid", 64'(c0_req_valid), 1);
      chk_val("t1_req_addr", 64'(c0_req_addr), 64'h100);
      chk_val("t1_req_mdata", 64'(c0_req_mdata), 0);
      pend.push_back({16'd0, 64'hDEAD});
      out_ready = 1'b1;
      step(); step();
      chk_val("t1_out_valid", 64'(out_valid), 1);
      chk_val("t1_out_index", 64'(out_index), 0);
      step();
      chk_val("t1_done", 64'(done), 1);
      chk_val("t1_busy_end", 64'(busy), 0);
      chk_val("t1_checksum", checksum, 64'hDEAD);
      chk_val("t1_out_empty", 64'(out_valid), 0);
      step();
      chk_val("t1_done_pulse", 64'(done), 0);
      chk_val("t1_req_count", 64'(req_addr_log.size() - rb), 1);

      // zero lines
      rb = req_addr_log.size();
      start_run(42'h200, 16'd0);
      chk_val("t2_done_e0", 64'(done), 0);
      chk_val("t2_busy", 64'(busy), 1);
      step();
      chk_val("t2_done_e1", 64'(done), 1);
      chk_val("t2_busy_end", 64'(busy), 0);
      chk_val("t2_checksum", checksum, 0);
      chk_val("t2_req_count", 64'(req_addr_log.size() - rb), 0);

      // out-of-order responses
      rb = req_addr_log.size();
      ob = out_idx_log.size();
      start_run(42'h2000, 16'd4);
      for (int i = 0; i < 20 && (req_addr_log.size() - rb) < 4; i++) step();
      chk_val("t3_req_count", 64'(req_addr_log.size() - rb), 4);
      chk_val("t3_addrs", 64'(addr_errs(rb, 42'h2000, 4)), 0);
      pend.push_back({16'd3, 64'd4});
      pend.push_back({16'd1, 64'd2});
      pend.push_back({16'd0, 64'd1});
      pend.push_back({16'd2, 64'd3});
      wait_done(40, "t3_done");
      chk_val("t3_checksum", checksum, 64'd10);
      chk_val("t3_out_count", 64'(out_idx_log.size() - ob), 4);
      bad = 0;
      if (out_idx_log.size() - ob == 4) begin
         if (out_idx_log[ob] !== 16'd3) bad++;
         if (out_idx_log[ob + 1] !== 16'd1) bad++;
         if (out_idx_log[ob + 2] !== 16'd0) bad++;
         if (out_idx_log[ob + 3] !== 16'd2) bad++;
      end else bad = 4;
      chk_val("t3_out_order", 64'(bad), 0);

      // credit limit, with the address wrapping through 2^42
      rb = req_addr_log.size();
      ob = out_idx_log.size();
      out_ready = 1'b0;
      auto_rsp  = 1'b1;
      start_run(42'h3FF_FFFF_FFF0, 16'd40);
      repeat (60) step();
      chk_val("t4_stall_count", 64'(req_addr_log.size() - rb), 16);
      chk_val("t4_stall_out_valid", 64'(out_valid), 1);
      chk_val("t4_stall_busy", 64'(busy), 1);
      out_ready = 1'b1;
      wait_done(400, "t4_done");
      chk_val("t4_req_count", 64'(req_addr_log.size() - rb), 40);
      chk_val("t4_out_count", 64'(out_idx_log.size() - ob), 40);
      chk_val("t4_checksum", checksum, 64'd820);
      chk_val("t4_addrs", 64'(addr_errs(rb, 42'h3FF_FFFF_FFF0, 40)), 0);
      bad = 0;
      for (int k = 0; k < 40; k++)
         if (ob + k >= out_idx_log.size() || out_idx_log[ob + k] !== 16'(k)) bad++;
      chk_val("t4_out_order", 64'(bad), 0);

      // almfull stall and start while busy
      rb = req_addr_log.size();
      start_run(42'h500, 16'd12);
      step(); step(); step();
      c0_tx_almfull = 1'b1;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (c0_req_valid) bad++;
         if (k == 1) begin
            start = 1'b1; base_addr = 42'h999; num_lines = 16'd3;
         end
         if (k == 2) start = 1'b0;
      end
      c0_tx_almfull = 1'b0;
      chk_val("t5_almfull_reqs", 64'(bad), 0);
      wait_done(200, "t5_done");
      chk_val("t5_req_count", 64'(req_addr_log.size() - rb), 12);
      chk_val("t5_addrs", 64'(addr_errs(rb, 42'h500, 12)), 0);
      chk_val("t5_checksum", checksum, 64'd78);
      repeat (10) step();
      chk_val("t5_req_after", 64'(req_addr_log.size() - rb), 12);
      chk_val("t5_busy_after", 64'(busy), 0);

      // reset in the middle of a run
      rb = req_addr_log.size();
      out_ready = 1'b0;
      start_run(42'h800, 16'd8);
      for (int i = 0; i < 20 && (req_addr_log.size() - rb) < 3; i++) step();
      chk_val("t6_pre_reqs", 64'(req_addr_log.size() - rb), 3);
      chk_val("t6_pre_req_valid", 64'(c0_req_valid), 1);
      chk_val("t6_pre_mdata", 64'(c0_req_mdata), 3);
      chk_val("t6_pre_out_valid", 64'(out_valid), 1);
      #2;
      reset_n = 1'b0;
      c0_rsp_valid = 1'b0;
      pend.delete();
      #1;
      chk_val("t6_rst_busy", 64'(busy), 0);
      chk_val("t6_rst_req_valid", 64'(c0_req_valid), 0);
      chk_val("t6_rst_req_addr", 64'(c0_req_addr), 0);
      chk_val("t6_rst_req_mdata", 64'(c0_req_mdata), 0);
      chk_val("t6_rst_out_valid", 64'(out_valid), 0);
      chk_val("t6_rst_done", 64'(done), 0);
      chk_val("t6_rst_checksum", checksum, 0);
      step(); step();
      reset_n = 1'b1;
      step();
      rb = req_addr_log.size();
      out_ready = 1'b1;
      start_run(42'h900, 16'd2);
      wait_done(60, "t6_done");
      chk_val("t6_checksum", checksum, 64'd3);
      chk_val("t6_req_count", 64'(req_addr_log.size() - rb), 2);
      chk_val("t6_addrs", 64'(addr_errs(rb, 42'h900, 2)), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
